// File: rtl/speed_frame_sequencer_pkg.sv
// speed_frame_sequencer_pkg: shared constants and parser state encoding for the speed display path
package speed_frame_sequencer_pkg;
   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [3:0] DASH_CODE   = 4'hF;
   localparam int         FRAME_ERR_W = 8;
   typedef enum logic [1:0] {HUNT, GOT_S, GOT_V, ACCEPT} parse_t;
endpackage

// File: rtl/speed_frame_sequencer_if.sv
// speed_frame_sequencer_if: received byte stream, msg valid while noti is high for one cycle
interface speed_frame_sequencer_if;
   logic [7:0] msg;
   logic       noti;
   modport master (output msg, noti);
   modport slave  (input msg, noti);
endinterface

// File: rtl/speed_frame_sequencer_bin2bcd.sv
// bin2bcd_seq: 0..99 binary to two BCD digits by repeated subtract-10, always 10 busy cycles
// ports: clk, rst (async), start/din load a value when idle; busy while converting;
//        done is high in the last busy cycle, with tens/ones valid during it
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] din,
   output logic       busy,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);
   logic [6:0] rem;
   logic [3:0] cnt;
   assign done = busy && cnt == 4'd9;
   assign ones = rem[3:0];
   // nine subtract steps cover 99; the tenth cycle only presents the result
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         busy <= 1'b0;
         rem  <= '0;
         tens <= '0;
         cnt  <= '0;
      end else if (start && !busy) begin
         busy <= 1'b1;
         rem  <= din;
         tens <= '0;
         cnt  <= '0;
      end else if (busy) begin
         cnt  <= cnt + 4'd1;
         busy <= !done;
         if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 4'd1;
         end
      end
endmodule

// File: rtl/speed_frame_sequencer.sv
// speed_frame_sequencer: validates SYNC/SPEED/CHK frames and schedules BCD display updates
// ports: clk, rst (async, active high); rx = msg/noti byte stream; peak_en selects peak hold;
//        digit_l/digit_r BCD (F = dash), blank, over, upd pulse on every commit,
//        frame_err saturating rejected-frame count
module speed_frame_sequencer
   import speed_frame_sequencer_pkg::*;
#(
   parameter logic [15:0] BYTE_TMO  = 16'd2000,
   parameter logic [21:0] STALE_CYC = 22'd3600000,
   parameter logic [21:0] PEAK_CYC  = 22'd1800000
) (
   input  logic                   clk,
   input  logic                   rst,
   speed_frame_sequencer_if.slave rx,
   input  logic                   peak_en,
   output logic [3:0]             digit_l,
   output logic [3:0]             digit_r,
   output logic                   blank,
   output logic                   over,
   output logic                   upd,
   output logic [FRAME_ERR_W-1:0] frame_err
);
   parse_t      state, state_n;
   logic [7:0]  spd, pend_spd, cur_spd, hold_key, disp_spd, new_key;
   logic [15:0] tmo_cnt;
   logic [21:0] stale_cnt, peak_cnt;
   logic        pend_v, ovr_q, in_frame, tmo, chk_ok, bad, acc, idle, disp, commit, take;
   logic        cv_start, cv_busy, cv_done;
   logic [3:0]  cv_tens, cv_ones;
   assign in_frame = state == GOT_S || state == GOT_V;
   assign tmo      = in_frame && !rx.noti && tmo_cnt == BYTE_TMO;
   assign chk_ok   = rx.msg == ~spd && spd != 8'hFF;
   assign bad      = (state == GOT_V && rx.noti && !chk_ok) || tmo;
   assign acc      = state == ACCEPT;
   // ovr_q is the one-cycle over-range commit stage, so it also blocks dispatch
   assign idle     = !cv_busy && !ovr_q;
   assign disp     = idle && (acc || pend_v);
   assign disp_spd = acc ? spd : pend_spd;
   assign cv_start = disp && disp_spd < 8'd100;
   assign commit   = cv_done || ovr_q;
   assign new_key  = ovr_q ? 8'hFF : cur_spd;
   // with peak_en low every commit is taken, so the held value is the live value
   assign take     = !peak_en || new_key > hold_key || peak_cnt == PEAK_CYC;
   always_comb begin
      state_n = state;
      case (state)
         HUNT:    state_n = rx.noti && rx.msg == SYNC_BYTE ? GOT_S : HUNT;
         GOT_S:   state_n = tmo ? HUNT : rx.noti ? GOT_V : GOT_S;
         GOT_V:   state_n = tmo ? HUNT : rx.noti ? (chk_ok ? ACCEPT : HUNT) : GOT_V;
         default: state_n = HUNT;
      endcase
   end
   bin2bcd_seq u_bcd (
      .clk(clk), .rst(rst), .start(cv_start), .din(disp_spd[6:0]),
      .busy(cv_busy), .done(cv_done), .tens(cv_tens), .ones(cv_ones)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= HUNT;
         spd       <= '0;
         tmo_cnt   <= '0;
         frame_err <= '0;
         pend_v    <= 1'b0;
         pend_spd  <= '0;
         ovr_q     <= 1'b0;
         cur_spd   <= '0;
         stale_cnt <= '0;
         peak_cnt  <= '0;
         hold_key  <= '0;
         blank     <= 1'b1;
         digit_l   <= '0;
         digit_r   <= '0;
         over      <= 1'b0;
         upd       <= 1'b0;
      end else begin
         state     <= state_n;
         if (state == GOT_S && rx.noti) spd <= rx.msg;
         tmo_cnt   <= rx.noti || !in_frame ? '0 : tmo_cnt + 16'd1;
         if (bad && ~&frame_err) frame_err <= frame_err + FRAME_ERR_W'(1);
         // latest accepted frame wins the single pending slot
         if (acc && !idle) begin
            pend_v   <= 1'b1;
            pend_spd <= spd;
         end else if (disp) pend_v <= 1'b0;
         ovr_q     <= disp && disp_spd >= 8'd100;
         if (disp) cur_spd <= disp_spd;
         stale_cnt <= acc ? '0 : stale_cnt + 22'(stale_cnt != STALE_CYC);
         blank     <= commit ? 1'b0 : stale_cnt == STALE_CYC ? 1'b1 : blank;
         peak_cnt  <= commit && take ? '0 : peak_cnt + 22'(peak_cnt != PEAK_CYC);
         if (commit && take) begin
            hold_key <= new_key;
            digit_l  <= ovr_q ? DASH_CODE : cv_tens;
            digit_r  <= ovr_q ? DASH_CODE : cv_ones;
            over     <= ovr_q;
         end
         upd       <= commit;
      end
endmodule

// File: tb/tb_speed_frame_sequencer.sv
// tb_speed_frame_sequencer: directed frame vectors plus timeout, stale, pending, peak and reset sequences
module tb_speed_frame_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       peak_en = 1'b0;
   logic [3:0] digit_l, digit_r;
   logic       blank, over, upd;
   logic [7:0] frame_err;
   int         n_chk = 0;
   int         n_fail = 0;
   int         lat;

   speed_frame_sequencer_if bus ();

   speed_frame_sequencer #(
      .BYTE_TMO(16'd20), .STALE_CYC(22'd200), .PEAK_CYC(22'd300)
   ) dut (
      .clk(clk), .rst(rst), .rx(bus), .peak_en(peak_en),
      .digit_l(digit_l), .digit_r(digit_r), .blank(blank), .over(over),
      .upd(upd), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b0, b1, b2;
      int lat, l, r, ov, ferr;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.msg  = b;
      bus.noti = 1'b1;
      @(negedge clk);
      bus.noti = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] s, input logic [7:0] c);
      send_byte(8'hA5);
      send_byte(s);
      send_byte(c);
   endtask

   // cycles from the negedge after the last byte until upd is seen, -1 if never within max
   task automatic wait_upd(input int max, output int l);
      bit seen = 1'b0;
      l = -1;
      for (int k = 0; k <= max && !seen; k++) begin
         if (upd) begin
            l = k;
            seen = 1'b1;
         end else @(negedge clk);
      end
   endtask

   task automatic chk_disp(input string nm, input int l, input int r, input int ov);
      chk({nm, " digit_l"}, int'(digit_l), l);
      chk({nm, " digit_r"}, int'(digit_r), r);
      chk({nm, " over"}, int'(over), ov);
   endtask

   initial begin
      logic [7:0] burst [9];
      bus.msg  = 8'h00;
      bus.noti = 1'b0;
      tbl[0]  = '{8'hA5, 8'h32, 8'hCD, 11, 5, 0, 0, 0};
      tbl[1]  = '{8'hA5, 8'h32, 8'h00, -1, 5, 0, 0, 1};
      tbl[2]  = '{8'hA5, 8'h07, 8'hF8, 11, 0, 7, 0, 1};
      tbl[3]  = '{8'hA5, 8'h63, 8'h9C, 11, 9, 9, 0, 1};
      tbl[4]  = '{8'hA5, 8'h00, 8'hFF, 11, 0, 0, 0, 1};
      tbl[5]  = '{8'hA5, 8'h64, 8'h9B, 2, 15, 15, 1, 1};
      tbl[6]  = '{8'hA5, 8'hFF, 8'h00, -1, 15, 15, 1, 2};
      tbl[7]  = '{8'hA5, 8'h0A, 8'hF5, 11, 1, 0, 0, 2};
      tbl[8]  = '{8'hA5, 8'hFE, 8'h01, 2, 15, 15, 1, 2};
      tbl[9]  = '{8'hA5, 8'hA5, 8'h5A, 2, 15, 15, 1, 2};
      tbl[10] = '{8'hA5, 8'h2D, 8'hD2, 11, 4, 5, 0, 2};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_disp("reset", 0, 0, 0);
      chk("reset blank", int'(blank), 1);
      chk("reset upd", int'(upd), 0);
      chk("reset frame_err", int'(frame_err), 0);

      for (int i = 0; i < 11; i++) begin
         send_byte(tbl[i].b0);
         send_byte(tbl[i].b1);
         send_byte(tbl[i].b2);
         wait_upd(30, lat);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk_disp($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, tbl[i].ov);
         chk($sformatf("vec%0d blank", i), int'(blank), 0);
         chk($sformatf("vec%0d frame_err", i), int'(frame_err), tbl[i].ferr);
         repeat (5) @(negedge clk);
      end

      send_byte(8'hA5);
      repeat (30) @(negedge clk);
      send_byte(8'h32);
      send_byte(8'hCD);
      wait_upd(30, lat);
      chk("timeout no upd", lat, -1);
      chk("timeout frame_err", int'(frame_err), 3);
      chk_disp("timeout", 4, 5, 0);

      send_byte(8'hA5);
      repeat (10) @(negedge clk);
      send_byte(8'h1E);
      repeat (10) @(negedge clk);
      send_byte(8'hE1);
      wait_upd(30, lat);
      chk("slow bytes latency", lat, 11);
      chk_disp("slow bytes", 3, 0, 0);
      chk("slow bytes frame_err", int'(frame_err), 3);

      send_frame(8'h78, 8'h87);
      wait_upd(30, lat);
      chk("over latency", lat, 2);
      chk_disp("over", 15, 15, 1);
      repeat (150) @(negedge clk);
      chk("stale early blank", int'(blank), 0);
      repeat (100) @(negedge clk);
      chk("stale blank", int'(blank), 1);
      chk_disp("stale", 15, 15, 1);
      send_frame(8'h1E, 8'hE1);
      wait_upd(30, lat);
      chk("unstale latency", lat, 11);
      chk("unstale blank", int'(blank), 0);
      chk_disp("unstale", 3, 0, 0);
      repeat (5) @(negedge clk);

      burst = '{8'hA5, 8'h1E, 8'hE1, 8'hA5, 8'h2D, 8'hD2, 8'hA5, 8'h32, 8'hCD};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.msg  = burst[i];
         bus.noti = 1'b1;
      end
      @(negedge clk);
      bus.noti = 1'b0;
      wait_upd(30, lat);
      chk("burst first latency", lat, 5);
      chk_disp("burst first", 3, 0, 0);
      @(negedge clk);
      wait_upd(30, lat);
      chk("burst pending latency", lat, 10);
      chk_disp("burst pending", 5, 0, 0);
      @(negedge clk);
      wait_upd(20, lat);
      chk("burst overwritten no upd", lat, -1);

      peak_en = 1'b1;
      send_frame(8'h3C, 8'hC3);
      wait_upd(30, lat);
      chk("peak 60 latency", lat, 11);
      chk_disp("peak 60", 6, 0, 0);
      repeat (5) @(negedge clk);
      send_frame(8'h28, 8'hD7);
      wait_upd(30, lat);
      chk("peak 40 latency", lat, 11);
      chk_disp("peak 40 held", 6, 0, 0);
      repeat (320) @(negedge clk);
      send_frame(8'h28, 8'hD7);
      wait_upd(30, lat);
      chk_disp("peak expired", 4, 0, 0);
      chk("peak expired blank", int'(blank), 0);
      repeat (5) @(negedge clk);
      send_frame(8'h78, 8'h87);
      wait_upd(30, lat);
      chk_disp("peak over", 15, 15, 1);
      repeat (5) @(negedge clk);
      send_frame(8'h63, 8'h9C);
      wait_upd(30, lat);
      chk("peak 99 latency", lat, 11);
      chk_disp("peak 99 held", 15, 15, 1);
      repeat (5) @(negedge clk);
      peak_en = 1'b0;
      send_frame(8'h14, 8'hEB);
      wait_upd(30, lat);
      chk_disp("live 20", 2, 0, 0);

      repeat (5) @(negedge clk);
      send_frame(8'h2D, 8'hD2);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_disp("midconv reset", 0, 0, 0);
      chk("midconv reset blank", int'(blank), 1);
      chk("midconv reset frame_err", int'(frame_err), 0);
      chk("midconv reset upd", int'(upd), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_upd(20, lat);
      chk("midconv reset no upd", lat, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
